// File: rtl/ec_point_double_unit_if.sv
// ec_point_double_unit_if: start/done bus between the scalar-multiplication
// controller (master) and the point-doubling unit (slave).
//   i_start       request level, held by the master until o_done
//   p             prime modulus
//   X1, Y1, Z1    Jacobian input point
//   a_coef        curve coefficient a (only with EC_PDBL_GENERIC_A_EN)
//   X3, Y3, Z3    Jacobian result point
//   o_busy        unit is computing
//   o_done        result valid, held until i_start drops
interface ec_point_double_unit_if #(parameter int W = 256);
  logic         i_start;
  logic [W-1:0] p;
  logic [W-1:0] X1, Y1, Z1;
`ifdef EC_PDBL_GENERIC_A_EN
  logic [W-1:0] a_coef;
`endif
  logic [W-1:0] X3, Y3, Z3;
  logic         o_busy;
  logic         o_done;

`ifdef EC_PDBL_GENERIC_A_EN
  modport master (output i_start, p, X1, Y1, Z1, a_coef, input X3, Y3, Z3, o_busy, o_done);
  modport slave  (input i_start, p, X1, Y1, Z1, a_coef, output X3, Y3, Z3, o_busy, o_done);
`else
  modport master (output i_start, p, X1, Y1, Z1, input X3, Y3, Z3, o_busy, o_done);
  modport slave  (input i_start, p, X1, Y1, Z1, output X3, Y3, Z3, o_busy, o_done);
`endif
endinterface

// File: rtl/ec_point_double_unit.sv
// ec_point_double_unit: Jacobian point doubling (X3,Y3,Z3) = 2*(X1,Y1,Z1) mod p
// on y^2 = x^3 + b (a = 0). A single bit-serial interleaved modular multiplier
// and a single one-cycle add/sub/double unit run a fixed micro-schedule, so the
// latency is fixed: 7*(W+1)+13 cycles from accept to o_done.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     ec_point_double_unit_if.slave (start/operands/result/busy/done)
// Optional feature: define EC_PDBL_GENERIC_A_EN to add bus.a_coef and compute
// E = 3*X1^2 + a*Z1^4 (latency becomes 10*(W+1)+14).
module ec_point_double_unit #(
  parameter int W = 256
) (
  input logic                   i_clk,
  input logic                   i_rst,
  ec_point_double_unit_if.slave bus
);

  localparam int CW = $clog2(W + 1);
`ifdef EC_PDBL_GENERIC_A_EN
  localparam int GA = 4;
`else
  localparam int GA = 0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {OP_MUL, OP_ADD, OP_SUB, OP_DBL, OP_WR} op_e;

  // register-file slots
  localparam logic [3:0] R_X1 = 4'd0,  R_Y1 = 4'd1,  R_Z1 = 4'd2,  R_A  = 4'd3,
                         R_B  = 4'd4,  R_C  = 4'd5,  R_T  = 4'd6,  R_D  = 4'd7,
                         R_E  = 4'd8,  R_F  = 4'd9,  R_G  = 4'd10, R_X3 = 4'd11,
                         R_Y3 = 4'd12, R_Z3 = 4'd13, R_H  = 4'd14, R_AC = 4'd15;

  typedef struct packed {
    op_e        op;
    logic [3:0] dst;
    logic [3:0] sa;
    logic [3:0] sb;
  } uop_t;

  // Micro-schedule. Doubling reads the same slot on both adder inputs.
  function automatic uop_t uop(input logic [4:0] s);
    uop_t u;
    u = '{OP_WR, R_X3, R_X3, R_X3};
    case (s)
      5'd0:        u = '{OP_MUL, R_A,  R_X1, R_X1};
      5'd1:        u = '{OP_MUL, R_B,  R_Y1, R_Y1};
      5'd2:        u = '{OP_MUL, R_C,  R_B,  R_B };
      5'd3:        u = '{OP_MUL, R_T,  R_X1, R_B };
      5'd4:        u = '{OP_DBL, R_D,  R_T,  R_T };
      5'd5:        u = '{OP_DBL, R_D,  R_D,  R_D };
      5'd6:        u = '{OP_ADD, R_E,  R_A,  R_A };
      5'd7:        u = '{OP_ADD, R_E,  R_E,  R_A };
`ifdef EC_PDBL_GENERIC_A_EN
      5'd8:        u = '{OP_MUL, R_H,  R_Z1, R_Z1};
      5'd9:        u = '{OP_MUL, R_H,  R_H,  R_H };
      5'd10:       u = '{OP_MUL, R_H,  R_AC, R_H };
      5'd11:       u = '{OP_ADD, R_E,  R_E,  R_H };
`endif
      5'(8  + GA): u = '{OP_MUL, R_F,  R_E,  R_E };
      5'(9  + GA): u = '{OP_DBL, R_G,  R_D,  R_D };
      5'(10 + GA): u = '{OP_SUB, R_X3, R_F,  R_G };
      5'(11 + GA): u = '{OP_SUB, R_G,  R_D,  R_X3};
      5'(12 + GA): u = '{OP_MUL, R_G,  R_E,  R_G };
      5'(13 + GA): u = '{OP_DBL, R_C,  R_C,  R_C };
      5'(14 + GA): u = '{OP_DBL, R_C,  R_C,  R_C };
      5'(15 + GA): u = '{OP_DBL, R_C,  R_C,  R_C };
      5'(16 + GA): u = '{OP_SUB, R_Y3, R_G,  R_C };
      5'(17 + GA): u = '{OP_MUL, R_Z3, R_Y1, R_Z1};
      5'(18 + GA): u = '{OP_DBL, R_Z3, R_Z3, R_Z3};
      default:     u = '{OP_WR,  R_X3, R_X3, R_X3};
    endcase
    return u;
  endfunction

  state_e         state_q, state_d;
  logic [4:0]     step_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   x3_q, y3_q, z3_q;

  logic [W-1:0]   rf [16];
  logic [W-1:0]   p_q;
  logic [W-1:0]   ma, mb, acc;

  uop_t           u;
  logic [W-1:0]   opa, opb;
  logic           accept;

  assign u      = uop(step_q);
  assign opa    = rf[u.sa];
  assign opb    = rf[u.sb];
  assign accept = (state_q == S_IDLE) && bus.i_start;

  // ---- one-cycle linear unit: add/double reduce by -p, subtract by +p ----
  logic [W+1:0] pp, lin_sum, lin_sub_p, lin_dif, lin_dif_p;
  logic [W-1:0] lin_res;
  always_comb begin
    pp        = {2'b0, p_q};
    lin_sum   = {2'b0, opa} + {2'b0, opb};
    lin_sub_p = lin_sum - pp;
    lin_dif   = {2'b0, opa} - {2'b0, opb};
    lin_dif_p = lin_dif + pp;
    if (u.op == OP_SUB)
      lin_res = lin_dif[W+1] ? lin_dif_p[W-1:0] : lin_dif[W-1:0];
    else
      lin_res = (lin_sum >= pp) ? lin_sub_p[W-1:0] : lin_sum[W-1:0];
  end

  // ---- multiplier iteration: R = 2R mod p, then R = R + a mod p if b[i] ----
  logic [W+1:0] m_dbl, m_dbl_r, m_add, m_add_r, m_next;
  always_comb begin
    m_dbl   = {1'b0, acc, 1'b0};
    m_dbl_r = (m_dbl >= pp) ? (m_dbl - pp) : m_dbl;
    m_add   = m_dbl_r + {2'b0, ma};
    m_add_r = (m_add >= pp) ? (m_add - pp) : m_add;
    m_next  = mb[W-1] ? m_add_r : m_dbl_r;
  end

  // Both results are < p < 2^W, so the top two bits are always zero.
  logic unused_hi;
  assign unused_hi = ^{m_next[W+1:W], lin_sub_p[W+1:W], lin_dif_p[W+1:W], lin_dif[W]};

  // ---- FSM ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.i_start)      state_d = S_RUN;
      S_RUN:  if (u.op == OP_WR)    state_d = S_DONE;
      S_DONE: if (!bus.i_start)     state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // ---- sequencing and result registers ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_q <= '0;
      cnt_q  <= '0;
      x3_q   <= '0;
      y3_q   <= '0;
      z3_q   <= '0;
    end else if (accept) begin
      step_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == S_RUN) begin
      case (u.op)
        OP_MUL: begin
          if (cnt_q == CW'(W)) begin
            cnt_q  <= '0;
            step_q <= step_q + 5'd1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        OP_WR: begin
          x3_q <= rf[R_X3];
          y3_q <= rf[R_Y3];
          z3_q <= rf[R_Z3];
        end
        default: step_q <= step_q + 5'd1;
      endcase
    end
  end

  // ---- operand capture and working registers (no reset needed) ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      p_q      <= bus.p;
      rf[R_X1] <= bus.X1;
      rf[R_Y1] <= bus.Y1;
      rf[R_Z1] <= bus.Z1;
`ifdef EC_PDBL_GENERIC_A_EN
      rf[R_AC] <= bus.a_coef;
`endif
    end else if (state_q == S_RUN) begin
      case (u.op)
        OP_MUL: begin
          if (cnt_q == '0) begin
            // load cycle: operands latched so dst may alias a source
            ma  <= opa;
            mb  <= opb;
            acc <= '0;
          end else begin
            acc <= m_next[W-1:0];
            mb  <= {mb[W-2:0], 1'b0};
            if (cnt_q == CW'(W)) rf[u.dst] <= m_next[W-1:0];
          end
        end
        OP_ADD, OP_DBL, OP_SUB: rf[u.dst] <= lin_res;
        default: ;
      endcase
    end
  end

  assign bus.X3     = x3_q;
  assign bus.Y3     = y3_q;
  assign bus.Z3     = z3_q;
  assign bus.o_busy = (state_q == S_RUN);
  assign bus.o_done = (state_q == S_DONE);

endmodule
